display_arbiter: RTL and testbench



---
 rtl/display_arbiter.sv | 170 +++++++++++++++++
 tb/tb_display_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares the 7-segment display word between NREQ overlay requesters and a
//   background source. Higher requester index has priority. A granted overlay
//   stays on the display for HOLD_CYCLES cycles after its most recent grant.
//   Lower-priority requests that arrive meanwhile are queued together with
//   their data and are served when the hold expires.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   bg_data      in   background (channel) display word
//   req          in   one-cycle request pulses, bit i = requester i
//   req_data     in   requester i's word at [i*DATA_W +: DATA_W]
//   display_data out  registered word to the display driver
//   active       out  an overlay currently owns the display
//   owner        out  index of the owning requester (valid when active)
//   grant        out  one-cycle pulse on every grant, preemption or refresh
//   pending      out  queued lower-priority requests
//
// Optional feature macro: BLINK_EN
//   When defined, the held word blinks (held word / zero, BLINK_DIV cycles per
//   phase) during the final quarter of the hold. When undefined, the held word
//   is shown steadily and no blink logic exists.

module display_arbiter #(
    parameter int NREQ        = 3,
    parameter int DATA_W      = 20,
    parameter int OWNER_W     = 2,
    parameter int HOLD_CYCLES = 2500000,
    parameter int TIMER_W     = 23,
    parameter int BLINK_DIV   = 250000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        bg_data,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [DATA_W-1:0]        display_data,
    output logic                     active,
    output logic [OWNER_W-1:0]       owner,
    output logic                     grant,
    output logic [NREQ-1:0]          pending
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    logic [0:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [DATA_W-1:0]  held_data;
    logic [DATA_W-1:0]  pend_data [NREQ];

    logic               expiry;
    logic [NREQ-1:0]    cand;
    logic [OWNER_W-1:0] win;
    logic               do_grant;
    logic [NREQ-1:0]    win_mask;
    logic [NREQ-1:0]    queue_mask;
    logic [DATA_W-1:0]  win_data;
    logic [DATA_W-1:0]  hold_view;

    function automatic logic [OWNER_W-1:0] top_index(input logic [NREQ-1:0] v);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        expiry = (state == ST_HOLD) && (timer == '0);
        // At expiry the queue competes with fresh requests; otherwise only
        // fresh requests can take the display.
        cand   = expiry ? (req | pending) : req;
        win    = top_index(cand);

        if (state == ST_IDLE) begin
            do_grant = |req;
        end else if (expiry) begin
            do_grant = |cand;
        end else begin
            // Equal index is a refresh, higher index preempts.
            do_grant = (|req) && (win >= owner);
        end

        win_mask   = do_grant ? (NREQ'(1) << win) : '0;
        // Every request that did not win is remembered; a preempted owner is
        // not in req and is therefore dropped.
        queue_mask = req & ~win_mask;
        win_data   = req[win] ? req_data[win*DATA_W +: DATA_W] : pend_data[win];
    end

`ifdef BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [TIMER_W-1:0] BLINK_START = TIMER_W'(HOLD_CYCLES / 4);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               blink_phase_next;
    logic [TIMER_W-1:0] timer_dec;

    always_comb begin
        timer_dec        = timer - 1'b1;
        blink_phase_next = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;
        // Decision is made on the values the registers take at this edge.
        hold_view        = ((timer_dec < BLINK_START) && blink_phase_next) ? '0 : held_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (do_grant) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == ST_HOLD) begin
            blink_phase <= blink_phase_next;
            blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        hold_view = held_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            held_data    <= '0;
            display_data <= '0;
            active       <= 1'b0;
            owner        <= '0;
            grant        <= 1'b0;
            pending      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                pend_data[i] <= '0;
            end
        end else begin
            grant   <= do_grant;
            pending <= (pending | queue_mask) & ~win_mask;
            for (int i = 0; i < NREQ; i++) begin
                if (queue_mask[i]) pend_data[i] <= req_data[i*DATA_W +: DATA_W];
            end

            if (do_grant) begin
                state        <= ST_HOLD;
                owner        <= win;
                held_data    <= win_data;
                display_data <= win_data;
                timer        <= TIMER_LOAD;
                active       <= 1'b1;
            end else if ((state == ST_HOLD) && !expiry) begin
                // timer is non-zero here, so it cannot wrap.
                timer        <= timer - 1'b1;
                display_data <= hold_view;
            end else begin
                state        <= ST_IDLE;
                active       <= 1'b0;
                display_data <= bg_data;
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter (NREQ=3, DATA_W=20, HOLD_CYCLES=10,
// BLINK_EN undefined). Directed scenarios plus a randomized run compared
// against a behavioural model of the arbitration rules.

module tb_display_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 20;
    localparam int OW   = 2;
    localparam int HOLD = 10;
    localparam int TW   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DW-1:0]        bg_data = '0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [DW-1:0]        display_data;
    logic                 active;
    logic [OW-1:0]        owner;
    logic                 grant;
    logic [NREQ-1:0]      pending;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the display, how many more cycles it
    // stays visible, and the queue of waiting requesters with their data.
    bit            m_active;
    int            m_owner;
    int            m_left;
    logic [DW-1:0] m_held;
    logic [DW-1:0] m_disp;
    bit            m_grant;
    logic [NREQ-1:0] m_pend;
    logic [DW-1:0] m_pdata [NREQ];

    display_arbiter #(
        .NREQ(NREQ), .DATA_W(DW), .OWNER_W(OW), .HOLD_CYCLES(HOLD),
        .TIMER_W(TW), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .bg_data(bg_data), .req(req), .req_data(req_data),
        .display_data(display_data), .active(active), .owner(owner),
        .grant(grant), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic int top_of(logic [NREQ-1:0] v);
        int t = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) t = i;
        return t;
    endfunction

    task automatic model_step();
        int win;
        if (rst) begin
            m_active = 0; m_owner = 0; m_left = 0; m_held = '0; m_disp = '0;
            m_grant = 0; m_pend = '0;
            for (int i = 0; i < NREQ; i++) m_pdata[i] = '0;
            return;
        end
        win = -1;
        if (!m_active) win = top_of(req);
        else if (m_left == 0) win = top_of(req | m_pend);
        else if (top_of(req) >= m_owner) win = top_of(req);
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && i != win) begin
                m_pend[i]  = 1'b1;
                m_pdata[i] = req_data[i*DW +: DW];
            end
        end
        if (win >= 0) begin
            m_held      = req[win] ? req_data[win*DW +: DW] : m_pdata[win];
            m_pend[win] = 1'b0;
            m_active    = 1;
            m_owner     = win;
            m_disp      = m_held;
            m_left      = HOLD - 1;
            m_grant     = 1;
        end else begin
            m_grant = 0;
            if (m_active && m_left > 0) begin
                m_left--;
                m_disp = m_held;
            end else begin
                m_active = 0;
                m_disp   = bg_data;
            end
        end
    endtask

    // One clock: inputs set beforehand are taken at the edge, outputs are
    // settled 1 time unit later, and request pulses are withdrawn.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        req = '0;
    endtask

    task automatic idle_out(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bg_data = 20'h00012; req = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (display_data !== '0 || active !== 1'b0 || owner !== '0 || grant !== 1'b0 || pending !== '0) begin
                errors++;
                $display("FAIL reset_outputs: disp=%h act=%b own=%0d gnt=%b pend=%b, required all zero",
                         display_data, active, owner, grant, pending);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (display_data !== 20'h00012 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: disp=%h act=%b, required 00012 / 0", display_data, active);
        end
    endtask

    task automatic test_single_hold();
        int act_cnt;
        req = 3'b010; req_data = {20'h0, 20'hD0050, 20'h0};
        step();
        checks++;
        if (grant !== 1'b1 || owner !== 2'd1 || active !== 1'b1 || display_data !== 20'hD0050) begin
            errors++;
            $display("FAIL single_grant: gnt=%b own=%0d act=%b disp=%h, required 1/1/1/D0050",
                     grant, owner, active, display_data);
        end
        act_cnt = 1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (active) begin
                act_cnt++;
                checks++;
                if (display_data !== 20'hD0050 || grant !== 1'b0) begin
                    errors++;
                    $display("FAIL single_hold_word: disp=%h gnt=%b, required D0050 / 0", display_data, grant);
                end
            end
        end
        checks++;
        if (act_cnt != 10) begin
            errors++;
            $display("FAIL single_duration: active cycles=%0d, required 10", act_cnt);
        end
        checks++;
        if (display_data !== 20'h00012 || active !== 1'b0) begin
            errors++;
            $display("FAIL single_release: disp=%h act=%b, required 00012 / 0", display_data, active);
        end
    endtask

    task automatic test_refresh();
        int g_cnt = 0, a_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            if (c == 0) begin req = 3'b010; req_data = {20'h0, 20'hA1111, 20'h0}; end
            if (c == 6) begin req = 3'b010; req_data = {20'h0, 20'hB2222, 20'h0}; end
            step();
            if (grant) g_cnt++;
            if (active) a_cnt++;
            if (c < 6) begin
                checks++;
                if (display_data !== 20'hA1111) begin
                    errors++;
                    $display("FAIL refresh_first_word: cycle %0d disp=%h, required A1111", c, display_data);
                end
            end else if (c < 16) begin
                checks++;
                if (display_data !== 20'hB2222) begin
                    errors++;
                    $display("FAIL refresh_second_word: cycle %0d disp=%h, required B2222", c, display_data);
                end
            end
        end
        checks++;
        if (g_cnt != 2 || a_cnt != 16) begin
            errors++;
            $display("FAIL refresh_counts: grants=%0d active=%0d, required 2 / 16", g_cnt, a_cnt);
        end
    endtask

    task automatic test_preempt();
        int a_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) begin req = 3'b001; req_data = {20'h0, 20'h0, 20'h0000A}; end
            if (c == 3) begin req = 3'b100; req_data = {20'h0000C, 20'h0, 20'h0}; end
            step();
            if (active) a_cnt++;
            if (c == 3) begin
                checks++;
                if (owner !== 2'd2 || pending !== 3'b000 || grant !== 1'b1 || display_data !== 20'h0000C) begin
                    errors++;
                    $display("FAIL preempt_switch: own=%0d pend=%b gnt=%b disp=%h, required 2/000/1/0000C",
                             owner, pending, grant, display_data);
                end
            end
        end
        checks++;
        if (a_cnt != 13) begin
            errors++;
            $display("FAIL preempt_duration: active cycles=%0d, required 13", a_cnt);
        end
    endtask

    task automatic test_queue();
        int a_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 0) begin req = 3'b100; req_data = {20'h0ABCD, 20'h0, 20'h0}; end
            if (c == 2) begin req = 3'b001; req_data = {20'h0, 20'h0, 20'h00777}; end
            step();
            if (active) a_cnt++;
            if (c == 2) begin
                checks++;
                if (pending !== 3'b001 || owner !== 2'd2 || grant !== 1'b0 || display_data !== 20'h0ABCD) begin
                    errors++;
                    $display("FAIL queue_enter: pend=%b own=%0d gnt=%b disp=%h, required 001/2/0/0ABCD",
                             pending, owner, grant, display_data);
                end
            end
            if (c == 10) begin
                checks++;
                if (owner !== 2'd0 || display_data !== 20'h00777 || pending !== 3'b000 || grant !== 1'b1) begin
                    errors++;
                    $display("FAIL queue_serve: own=%0d disp=%h pend=%b gnt=%b, required 0/00777/000/1",
                             owner, display_data, pending, grant);
                end
            end
        end
        checks++;
        if (a_cnt != 20) begin
            errors++;
            $display("FAIL queue_duration: active cycles=%0d, required 20", a_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int a_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0)  begin req = 3'b100; req_data = {20'h0000C, 20'h0, 20'h0}; end
            if (c == 2)  begin req = 3'b010; req_data = {20'h0, 20'h00BEE, 20'h0}; end
            if (c == 10) begin req = 3'b001; req_data = {20'h0, 20'h0, 20'h00DAD}; end
            step();
            if (active) a_cnt++;
            if (c == 10) begin
                checks++;
                if (owner !== 2'd1 || display_data !== 20'h00BEE || pending !== 3'b001 || grant !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_from_slot: own=%0d disp=%h pend=%b gnt=%b, required 1/00BEE/001/1",
                             owner, display_data, pending, grant);
                end
            end
            if (c == 20) begin
                checks++;
                if (owner !== 2'd0 || display_data !== 20'h00DAD || pending !== 3'b000) begin
                    errors++;
                    $display("FAIL simul_second: own=%0d disp=%h pend=%b, required 0/00DAD/000",
                             owner, display_data, pending);
                end
            end
        end
        checks++;
        if (a_cnt != 30) begin
            errors++;
            $display("FAIL simul_duration: active cycles=%0d, required 30", a_cnt);
        end
    endtask

    task automatic test_expiry_refresh();
        int a_cnt = 0, g_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 0)  begin req = 3'b010; req_data = {20'h0, 20'h11111, 20'h0}; end
            if (c == 10) begin req = 3'b010; req_data = {20'h0, 20'h22222, 20'h0}; end
            step();
            if (active) a_cnt++;
            if (grant) g_cnt++;
            if (c == 10) begin
                checks++;
                if (active !== 1'b1 || display_data !== 20'h22222) begin
                    errors++;
                    $display("FAIL expiry_refresh_edge: act=%b disp=%h, required 1 / 22222", active, display_data);
                end
            end
        end
        checks++;
        if (a_cnt != 20 || g_cnt != 2) begin
            errors++;
            $display("FAIL expiry_refresh_counts: active=%0d grants=%0d, required 20 / 2", a_cnt, g_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        req = 3'b100; req_data = {20'h0F00D, 20'h0, 20'h0};
        step();
        req = 3'b001; req_data = {20'h0, 20'h0, 20'h00123};
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (display_data !== '0 || active !== 1'b0 || owner !== '0 || grant !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold: disp=%h act=%b own=%0d gnt=%b pend=%b, required all zero",
                     display_data, active, owner, grant, pending);
        end
        rst = 1'b0;
        step();
        checks++;
        if (display_data !== bg_data || active !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold_after: disp=%h act=%b pend=%b, required %h/0/000",
                     display_data, active, pending, bg_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) bg_data = DW'($urandom);
            req = ($urandom_range(0, 4) == 0) ? NREQ'($urandom) : '0;
            req_data = {DW'($urandom), DW'($urandom), DW'($urandom)};
            step();
            rst = 1'b0;
            checks++;
            if (display_data !== m_disp) begin
                errors++;
                $display("FAIL rand_display: cycle %0d got %h, required %h", c, display_data, m_disp);
            end
            checks++;
            if (active !== m_active) begin
                errors++;
                $display("FAIL rand_active: cycle %0d got %b, required %b", c, active, m_active);
            end
            checks++;
            if (grant !== m_grant) begin
                errors++;
                $display("FAIL rand_grant: cycle %0d got %b, required %b", c, grant, m_grant);
            end
            checks++;
            if (pending !== m_pend) begin
                errors++;
                $display("FAIL rand_pending: cycle %0d got %b, required %b", c, pending, m_pend);
            end
            if (m_active) begin
                checks++;
                if (owner !== OW'(m_owner)) begin
                    errors++;
                    $display("FAIL rand_owner: cycle %0d got %0d, required %0d", c, owner, m_owner);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        idle_out(3);
        test_refresh();
        idle_out(3);
        test_preempt();
        idle_out(3);
        test_queue();
        idle_out(3);
        test_simultaneous();
        idle_out(3);
        test_expiry_refresh();
        idle_out(3);
        test_reset_mid_hold();
        idle_out(3);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
